fetch_ctrl: RTL

//  Sequences instruction-memory fetches for stage1 and owns the fetch PC.

---
 rtl/fetch_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: owns the fetch PC, issues in-order imem requests, kills stale responses after redirects
// and buffers {pc,instr} pairs toward decode. Define FENCE_I_FLUSH_EN for fence.i flush/restart sequencing.
module fetch_ctrl #(
    parameter int unsigned     PC_W            = 48,
    parameter logic [PC_W-1:0] RESET_PC        = '0,
    parameter int unsigned     FETCH_Q_DEPTH   = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    output logic [PC_W-1:0] bp_pc_o,
    input  logic            bp_taken_i,
    input  logic [PC_W-1:0] bp_target_i,
    output logic            imem_req_o,
    output logic [PC_W-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            dec_valid_o,
    output logic [PC_W-1:0] dec_pc_o,
    output logic [31:0]     dec_instr_o,
    input  logic            dec_ready_i
`ifdef FENCE_I_FLUSH_EN
    ,
    input  logic            fence_i_req_i,
    input  logic [PC_W-1:0] fence_i_pc_i,
    output logic            fence_i_done_o
`endif
);
    localparam int QW = $clog2(FETCH_Q_DEPTH);
    localparam int CW = QW + 1;
    localparam int SW = CW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

`ifdef FENCE_I_FLUSH_EN
    typedef enum logic [1:0] {IDLE, RUN, FENCE_WAIT, FENCE_RESTART} state_t;
`else
    typedef enum logic {IDLE, RUN} state_t;
`endif

    state_t          r_state;
    logic [PC_W-1:0] r_fetch_pc;
    logic [OW-1:0]   r_out;
    logic [OW-1:0]   r_kill;
    logic [PC_W-1:0] r_if_pc [MAX_OUTSTANDING];
    logic [IW-1:0]   r_if_wp;
    logic [IW-1:0]   r_if_rp;
    logic [PC_W-1:0] r_q_pc [FETCH_Q_DEPTH];
    logic [31:0]     r_q_instr [FETCH_Q_DEPTH];
    logic [QW-1:0]   r_q_wp;
    logic [QW-1:0]   r_q_rp;
    logic [CW-1:0]   r_q_cnt;
    logic            w_fence;
    logic            w_flush;
    logic            w_issue;
    logic            w_push;
    logic            w_pop;

`ifdef FENCE_I_FLUSH_EN
    logic [PC_W-1:0] r_fence_pc;
    logic            r_fence_done;
    assign w_fence        = r_state == RUN && fence_i_req_i;
    assign fence_i_done_o = r_fence_done;
`else
    assign w_fence = 1'b0;
`endif

    // Credit rule: every granted request already owns a FIFO slot, so responses can never overflow.
    always_comb begin
        dec_valid_o = r_q_cnt != '0;
        dec_pc_o    = r_q_pc[r_q_rp];
        dec_instr_o = r_q_instr[r_q_rp];
        bp_pc_o     = r_fetch_pc;
        imem_addr_o = r_fetch_pc;
        w_flush     = redirect_i || w_fence;
        imem_req_o  = r_state == RUN && !w_flush && r_out < OW'(MAX_OUTSTANDING)
                      && {1'b0, r_q_cnt} + SW'(r_out) < SW'(FETCH_Q_DEPTH);
        w_issue     = imem_req_o && imem_gnt_i;
        w_push      = imem_rvalid_i && r_kill == '0 && !w_flush;
        w_pop       = dec_valid_o && dec_ready_i && !w_flush;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_out      <= '0;
            r_kill     <= '0;
            r_if_wp    <= '0;
            r_if_rp    <= '0;
            r_q_wp     <= '0;
            r_q_rp     <= '0;
            r_q_cnt    <= '0;
`ifdef FENCE_I_FLUSH_EN
            r_fence_pc   <= '0;
            r_fence_done <= 1'b0;
`endif
        end else begin
            r_out  <= r_out + OW'(w_issue) - OW'(imem_rvalid_i);
            // On a flush everything still in flight is stale, including what arrives later.
            r_kill <= w_flush ? r_out - OW'(imem_rvalid_i)
                    : (imem_rvalid_i && r_kill != '0) ? r_kill - OW'(1) : r_kill;
            if (w_issue) begin
                r_if_pc[r_if_wp] <= r_fetch_pc;
                r_if_wp          <= r_if_wp == IW'(MAX_OUTSTANDING - 1) ? '0 : r_if_wp + IW'(1);
            end
            if (imem_rvalid_i)
                r_if_rp <= r_if_rp == IW'(MAX_OUTSTANDING - 1) ? '0 : r_if_rp + IW'(1);
            if (w_push) begin
                r_q_pc[r_q_wp]    <= r_if_pc[r_if_rp];
                r_q_instr[r_q_wp] <= imem_rdata_i;
            end
            r_q_wp     <= w_flush ? '0 : r_q_wp + QW'(w_push);
            r_q_rp     <= w_flush ? '0 : r_q_rp + QW'(w_pop);
            r_q_cnt    <= w_flush ? '0 : r_q_cnt + CW'(w_push) - CW'(w_pop);
            r_fetch_pc <= redirect_i ? redirect_pc_i
                        : w_issue ? (bp_taken_i ? bp_target_i : r_fetch_pc + PC_W'(4)) : r_fetch_pc;
`ifdef FENCE_I_FLUSH_EN
            r_fence_done <= r_state == FENCE_RESTART && !redirect_i;
            case (r_state)
                IDLE: r_state <= RUN;
                RUN: begin
                    if (w_fence && !redirect_i) begin
                        r_state    <= FENCE_WAIT;
                        r_fence_pc <= fence_i_pc_i;
                    end
                end
                FENCE_WAIT: r_state <= redirect_i ? RUN : r_out == '0 ? FENCE_RESTART : FENCE_WAIT;
                default: begin
                    r_state <= RUN;
                    if (!redirect_i)
                        r_fetch_pc <= r_fence_pc;
                end
            endcase
`else
            r_state <= RUN;
`endif
        end
    end

    always_ff @(posedge clk)
        if (!reset)
            assert (!(w_push && r_q_cnt == CW'(FETCH_Q_DEPTH)));

endmodule
